// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream_demux block.
// Optional broadcast support is controlled by the STREAM_DEMUX_BCAST_EN macro.
package stream_demux_pkg;

    localparam int MAX_CH = 16;

    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;

    // Bounded loop keeps this usable where $clog2 is unavailable.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle between one producer and N_CH consumers of stream_demux.
// in_bcast exists only when STREAM_DEMUX_BCAST_EN is defined.
interface stream_demux_if #(
    parameter int N_CH = 8,
    parameter int DW   = 8
);
    import stream_demux_pkg::*;

    localparam int SELW = clog2(N_CH);

    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    logic [SELW-1:0]      in_sel;
    logic [N_CH-1:0]      out_valid;
    logic [N_CH-1:0]      out_ready;
    logic [N_CH*DW-1:0]   out_data;
    logic                 drop_pulse;
`ifdef STREAM_DEMUX_BCAST_EN
    logic                 in_bcast;
`endif

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_sel,
        input  out_valid,
        output out_ready,
        input  out_data,
`ifdef STREAM_DEMUX_BCAST_EN
        output in_bcast,
`endif
        input  drop_pulse
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_sel,
        output out_valid,
        input  out_ready,
        output out_data,
`ifdef STREAM_DEMUX_BCAST_EN
        input  in_bcast,
`endif
        output drop_pulse
    );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry register slice holding a single beat for one output channel.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_ready,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          state_r;
    logic [DW-1:0] data_r;

    // A write wins over a drain so a full slot sustains one beat per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= SLOT_EMPTY;
            data_r  <= '0;
        end else if (wr_en) begin
            state_r <= SLOT_FULL;
            data_r  <= wr_data;
        end else if ((state_r == SLOT_FULL) && rd_ready) begin
            state_r <= SLOT_EMPTY;
            data_r  <= data_r;
        end else begin
            state_r <= state_r;
            data_r  <= data_r;
        end
    end

    assign valid = (state_r == SLOT_FULL);
    assign data  = data_r;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N_CH stream demultiplexer with per-channel holding slots.
// Define STREAM_DEMUX_BCAST_EN to add the in_bcast broadcast input.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int DW   = 8
) (
    input logic           clk,
    input logic           rst_n,
    stream_demux_if.slave bus
);

    localparam int              SELW   = clog2(N_CH);
    localparam logic [SELW:0]   CH_LIM = N_CH[SELW:0];

    logic                       bcast_s;
    logic                       sel_ok_s;
    logic                       in_ready_s;
    logic                       xfer_s;
    logic [N_CH-1:0]            wr_en_s;
    logic [N_CH-1:0]            valid_s;
    logic [N_CH-1:0][DW-1:0]    data_s;
    logic                       drop_r;

`ifdef STREAM_DEMUX_BCAST_EN
    assign bcast_s = bus.in_bcast;
`else
    assign bcast_s = 1'b0;
`endif

    // Indices >= N_CH only exist when N_CH is not a power of two.
    assign sel_ok_s = ({1'b0, bus.in_sel} < CH_LIM);

    // Acceptance and per-slot write decode.
    always_comb begin
        in_ready_s = 1'b0;
        xfer_s     = 1'b0;
        wr_en_s    = '0;
        if (!rst_n) begin
            in_ready_s = 1'b0;
        end else if (bcast_s) begin
            in_ready_s = &(~valid_s | bus.out_ready);
        end else if (!sel_ok_s) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = ~valid_s[bus.in_sel] | bus.out_ready[bus.in_sel];
        end
        xfer_s = bus.in_valid & in_ready_s;
        for (int k = 0; k < N_CH; k++) begin
            wr_en_s[k] = xfer_s & (bcast_s | (sel_ok_s & (bus.in_sel == SELW'(k))));
        end
    end

    // Flags a unicast beat that was swallowed because no slot matches in_sel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_r <= 1'b0;
        end else begin
            drop_r <= xfer_s & ~bcast_s & ~sel_ok_s;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        demux_slot #(.DW(DW)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en_s[g]),
            .wr_data  (bus.in_data),
            .rd_ready (bus.out_ready[g]),
            .valid    (valid_s[g]),
            .data     (data_s[g])
        );
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = valid_s;
    assign bus.out_data   = data_s;
    assign bus.drop_pulse = drop_r;

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux (N_CH=8 and N_CH=6 instances).
// Broadcast steps are compiled in when STREAM_DEMUX_BCAST_EN is defined.
module tb_stream_demux;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    stream_demux_if #(.N_CH(8), .DW(8)) bus_a ();
    stream_demux_if #(.N_CH(6), .DW(8)) bus_b ();

    stream_demux #(.N_CH(8), .DW(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    stream_demux #(.N_CH(6), .DW(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_sel    = 3'd3;
        bus_a.in_data   = 8'hA5;
        bus_a.out_ready = 8'h00;
        bus_b.in_valid  = 1'b1;
        bus_b.in_sel    = 3'd7;
        bus_b.in_data   = 8'hFF;
        bus_b.out_ready = 6'h00;
`ifdef STREAM_DEMUX_BCAST_EN
        bus_a.in_bcast  = 1'b0;
        bus_b.in_bcast  = 1'b0;
`endif

        // Reset held two cycles with traffic offered
        tick();
        tick();
        check("rst_out_valid", 64'(bus_a.out_valid), 64'h0);
        check("rst_out_data",  64'(bus_a.out_data), 64'h0);
        check("rst_drop",      64'(bus_a.drop_pulse), 64'h0);
        check("rst_in_ready",  64'(bus_a.in_ready), 64'h0);
        check("rst_b_in_ready", 64'(bus_b.in_ready), 64'h0);
        check("rst_b_drop",    64'(bus_b.drop_pulse), 64'h0);

        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("idle_out_valid", 64'(bus_a.out_valid), 64'h0);

        // Unicast to slot 3, consumer stalled
        bus_a.in_valid = 1'b1;
        bus_a.in_sel   = 3'd3;
        bus_a.in_data  = 8'hA5;
        #1;
        check("uni_in_ready_empty", 64'(bus_a.in_ready), 64'h1);
        tick();
        bus_a.in_valid = 1'b0;
        #1;
        check("uni_out_valid", 64'(bus_a.out_valid), 64'h08);
        check("uni_slot3",     64'(bus_a.out_data[31:24]), 64'hA5);
        check("uni_in_ready_full", 64'(bus_a.in_ready), 64'h0);
        check("uni_drop",      64'(bus_a.drop_pulse), 64'h0);
        tick();
        check("hold_out_valid", 64'(bus_a.out_valid), 64'h08);
        check("hold_slot3",     64'(bus_a.out_data[31:24]), 64'hA5);

        // Full-throughput stream into slot 3
        bus_a.out_ready = 8'h08;
        bus_a.in_valid  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus_a.in_data = 8'(i);
            #1;
            check("tput_in_ready", 64'(bus_a.in_ready), 64'h1);
            tick();
            check("tput_valid", 64'(bus_a.out_valid), 64'h08);
            check("tput_data",  64'(bus_a.out_data[31:24]), 64'(i));
        end
        bus_a.in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(bus_a.out_valid), 64'h00);
        check("drain_data_held", 64'(bus_a.out_data[31:24]), 64'h10);

        // Independent slots 0 and 7, concurrent drain
        bus_a.out_ready = 8'h00;
        bus_a.in_valid  = 1'b1;
        bus_a.in_sel    = 3'd0;
        bus_a.in_data   = 8'h5A;
        tick();
        bus_a.in_sel    = 3'd7;
        bus_a.in_data   = 8'h77;
        tick();
        bus_a.in_valid  = 1'b0;
        check("indep_valid", 64'(bus_a.out_valid), 64'h81);
        check("indep_slot0", 64'(bus_a.out_data[7:0]), 64'h5A);
        check("indep_slot7", 64'(bus_a.out_data[63:56]), 64'h77);
        bus_a.out_ready = 8'h81;
        tick();
        check("indep_drain", 64'(bus_a.out_valid), 64'h00);

        // Simultaneous drain and write on slot 5
        bus_a.out_ready = 8'h00;
        bus_a.in_valid  = 1'b1;
        bus_a.in_sel    = 3'd5;
        bus_a.in_data   = 8'h11;
        tick();
        check("sim_fill_valid", 64'(bus_a.out_valid), 64'h20);
        check("sim_fill_slot5", 64'(bus_a.out_data[47:40]), 64'h11);
        bus_a.out_ready = 8'h20;
        bus_a.in_data   = 8'h22;
        #1;
        check("sim_in_ready", 64'(bus_a.in_ready), 64'h1);
        tick();
        bus_a.in_valid = 1'b0;
        check("sim_valid", 64'(bus_a.out_valid), 64'h20);
        check("sim_slot5", 64'(bus_a.out_data[47:40]), 64'h22);
        tick();
        check("sim_drain", 64'(bus_a.out_valid), 64'h00);
        bus_a.out_ready = 8'h00;

        // Out-of-range select on the 6-channel instance
        bus_b.in_valid = 1'b1;
        bus_b.in_sel   = 3'd7;
        bus_b.in_data  = 8'hFF;
        #1;
        check("oor_in_ready", 64'(bus_b.in_ready), 64'h1);
        tick();
        bus_b.in_valid = 1'b0;
        check("oor_drop", 64'(bus_b.drop_pulse), 64'h1);
        check("oor_valid", 64'(bus_b.out_valid), 64'h00);
        tick();
        check("oor_drop_clear", 64'(bus_b.drop_pulse), 64'h0);
        bus_b.in_valid = 1'b1;
        bus_b.in_sel   = 3'd5;
        bus_b.in_data  = 8'h3E;
        tick();
        bus_b.in_valid = 1'b0;
        check("b_inrange_valid", 64'(bus_b.out_valid), 64'h20);
        check("b_inrange_slot5", 64'(bus_b.out_data[47:40]), 64'h3E);
        check("b_inrange_drop",  64'(bus_b.drop_pulse), 64'h0);

`ifdef STREAM_DEMUX_BCAST_EN
        // Broadcast blocked by stalled slot 2, then released
        bus_a.in_valid = 1'b1;
        bus_a.in_sel   = 3'd2;
        bus_a.in_data  = 8'h42;
        tick();
        bus_a.in_bcast = 1'b1;
        bus_a.in_data  = 8'h3C;
        #1;
        check("bc_in_ready_blocked", 64'(bus_a.in_ready), 64'h0);
        tick();
        check("bc_blocked_valid", 64'(bus_a.out_valid), 64'h04);
        check("bc_blocked_slot2", 64'(bus_a.out_data[23:16]), 64'h42);
        bus_a.out_ready = 8'h04;
        #1;
        check("bc_in_ready_free", 64'(bus_a.in_ready), 64'h1);
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.in_bcast = 1'b0;
        bus_a.out_ready = 8'h00;
        check("bc_valid", 64'(bus_a.out_valid), 64'hFF);
        check("bc_data",  64'(bus_a.out_data), 64'h3C3C_3C3C_3C3C_3C3C);
        check("bc_drop",  64'(bus_a.drop_pulse), 64'h0);
`endif

        // Reset overrides held beats
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_b_valid", 64'(bus_b.out_valid), 64'h00);
        check("rst2_b_data",  64'(bus_b.out_data), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
